click_sync_sink: RTL and testbench

//  Clocked receiving end of a 2-phase (transition-signalling) bundled-data click pipeline.
//  - Consumes the toggling request from the last click stage and captures the bundled data.
//  - Returns a toggling acknowledge and presents the tokens to synchronous logic

---
 rtl/click_pkg.sv | 23 ++
 rtl/click_sync.sv | 23 ++
 rtl/click_sync_sink.sv | 145 ++++++++++++++
 tb/tb_click_sync_sink.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/click_pkg.sv
// Shared definitions for the click-pipeline synchronous boundary blocks:
// FSM state encodings, default widths and a pointer-width helper.
package click_pkg;

  // Sink FSM state encodings
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_STALL = 1'b1;

  // Default configuration
  localparam int CLICK_DW          = 8;
  localparam int CLICK_SYNC_STAGES = 2;

  // Smallest n with 2**n >= value (value >= 1)
  function automatic int clog2(input int value);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/click_sync.sv
// Multi-flop synchronizer for a single asynchronous level (e.g. a 2-phase
// request). All stages clear on synchronous active-low reset.
module click_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_rstn) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/click_sync_sink.sv
// Clocked tail of a 2-phase bundled-data click pipeline. The toggling request
// is synchronized, compared against the local acknowledge phase, and each new
// token is pushed into a small FIFO drained through a valid/ready port.
// Optional feature: define CLICK_SINK_ERR_EN to enable the sticky o_err flag
// that reports an upstream double toggle (lost token).
module click_sync_sink
  import click_pkg::*;
#(
  parameter int DW          = CLICK_DW,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = CLICK_SYNC_STAGES
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_req,
  input  logic [DW-1:0] i_data,
  output logic          o_ack,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  input  logic          i_ready,
  output logic          o_stall,
  output logic          o_err
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic          w_req_s;
  logic          w_pending;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_state_next;
  logic [PW-1:0] w_wr_ptr_next;
  logic [PW-1:0] w_rd_ptr_next;
  logic [DW-1:0] w_head_next;

  logic          r_state;
  logic          r_ack;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [DW-1:0] r_head;
  logic [DW-1:0] r_mem [DEPTH];

  click_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_d    (i_req),
    .o_q    (w_req_s)
  );

  // A token is waiting whenever the synchronized request phase differs from ack
  assign w_pending = w_req_s ^ r_ack;
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_pop     = !w_empty && i_ready;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // FSM next state: stall while a token waits on a full FIFO
  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_pending && w_full) w_state_next = ST_STALL;
      ST_STALL: if (!w_full)             w_state_next = ST_IDLE;
      default:                           w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: push uses registered full, so a pop while full costs one bubble
  always_comb begin
    w_push  = w_pending && !w_full;
    o_stall = (r_state == ST_STALL);
  end

  assign w_wr_ptr_next = r_wr_ptr + PW'(w_push);
  assign w_rd_ptr_next = r_rd_ptr + PW'(w_pop);

  // Head after this edge: zero when empty, bypass when the new head is being written
  always_comb begin
    w_head_next = '0;
    if (w_wr_ptr_next != w_rd_ptr_next) begin
      if (w_push && (r_wr_ptr == w_rd_ptr_next)) w_head_next = i_data;
      else                                        w_head_next = r_mem[w_rd_ptr_next[AW-1:0]];
    end
  end

  // FIFO storage write
  always_ff @(posedge i_clk) begin
    // NOTE: storage is deliberately not reset; the pointers define which entries are valid.
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // Pointers, acknowledge phase and registered head
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ack    <= 1'b0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_head   <= w_head_next;
      if (w_push) r_ack <= ~r_ack;
    end
  end

  assign o_ack   = r_ack;
  assign o_valid = !w_empty;
  assign o_data  = r_head;

`ifdef CLICK_SINK_ERR_EN
  logic r_req_d;
  logic r_err;
  logic w_req_edge;
  logic w_pending_prev;

  assign w_req_edge     = w_req_s ^ r_req_d;
  assign w_pending_prev = r_req_d ^ r_ack;

  // Flag a second request toggle arriving before the first token was acked
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_req_d <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_req_d <= w_req_s;
      if (w_req_edge && w_pending_prev && !w_push) r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_click_sync_sink.sv
// Directed testbench for click_sync_sink: reset, single token latency,
// back-pressure with stall and bubble, wrap-around streaming, mid-operation
// reset, and the optional double-toggle error flag.
module tb_click_sync_sink;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_req;
  logic [7:0] i_data;
  logic       o_ack;
  logic       o_valid;
  logic [7:0] o_data;
  logic       i_ready;
  logic       o_stall;
  logic       o_err;

  int   n_pass  = 0;
  int   n_total = 0;
  logic exp_ack;
  logic exp_err;
  int   got_cnt;
  int   ack_cnt;
  logic seen;

  always #5 i_clk = ~i_clk;

  click_sync_sink dut (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_req   (i_req),
    .i_data  (i_data),
    .o_ack   (o_ack),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready),
    .o_stall (o_stall),
    .o_err   (o_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Upstream click stage: present data, toggle request, wait (bounded) for ack
  task automatic send(input logic [7:0] d);
    @(negedge i_clk);
    i_data  = d;
    i_req   = ~i_req;
    exp_ack = ~exp_ack;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (o_ack === exp_ack) break;
    end
    check("send_ack", o_ack, exp_ack);
    if (o_ack === exp_ack) ack_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef CLICK_SINK_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    i_rstn  = 1'b0;
    i_req   = 1'b1;
    i_data  = 8'h00;
    i_ready = 1'b0;
    exp_ack = 1'b0;
    ack_cnt = 0;

    // Reset held 3 cycles with request high
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      check("rst_ack",   o_ack,   0);
      check("rst_valid", o_valid, 0);
      check("rst_stall", o_stall, 0);
      check("rst_err",   o_err,   0);
      check("rst_data",  o_data,  0);
    end
    i_rstn = 1'b1;
    i_req  = 1'b0;
    repeat (2) @(negedge i_clk);

    // Single token: ack and valid three edges after the toggle
    i_data  = 8'hA5;
    i_req   = 1'b1;
    i_ready = 1'b1;
    exp_ack = 1'b1;
    @(negedge i_clk); check("single_ack_e1", o_ack, 0);
    @(negedge i_clk); check("single_ack_e2", o_ack, 0);
    @(negedge i_clk);
    check("single_ack_e3",   o_ack,   1);
    check("single_valid_e3", o_valid, 1);
    check("single_data_e3",  o_data,  8'hA5);
    @(negedge i_clk);
    check("single_valid_e4", o_valid, 0);
    check("single_data_e4",  o_data,  0);

    // Back-pressure: four tokens fill the FIFO, the fifth stalls
    i_ready = 1'b0;
    for (int t = 1; t <= 4; t++) send(8'(t));
    @(negedge i_clk);
    i_data = 8'h05;
    i_req  = ~i_req;
    repeat (3) @(negedge i_clk);
    check("bp_stall_e3", o_stall, 1);
    check("bp_ack_held", o_ack,   exp_ack);
    repeat (2) @(negedge i_clk);
    check("bp_stall_hold", o_stall, 1);
    check("bp_ack_hold",   o_ack,   exp_ack);
    check("bp_valid",      o_valid, 1);
    check("bp_head",       o_data,  8'h01);
    i_ready = 1'b1;
    @(negedge i_clk);
    check("bp_pop1_data",  o_data,  8'h02);
    check("bp_pop1_ack",   o_ack,   exp_ack);
    check("bp_pop1_stall", o_stall, 1);
    @(negedge i_clk);
    exp_ack = ~exp_ack;
    check("bp_pop2_data",  o_data,  8'h03);
    check("bp_pop2_ack",   o_ack,   exp_ack);
    check("bp_pop2_stall", o_stall, 0);
    @(negedge i_clk); check("bp_pop3_data", o_data, 8'h04);
    @(negedge i_clk); check("bp_pop4_data", o_data, 8'h05);
    @(negedge i_clk);
    check("bp_empty_valid", o_valid, 0);
    check("bp_empty_data",  o_data,  0);

    // Wrap-around: 20 tokens with i_ready toggling every cycle
    ack_cnt = 0;
    got_cnt = 0;
    fork
      begin
        for (int t = 0; t < 20; t++) send(8'(8'h10 + t));
      end
      begin
        int k;
        k = 0;
        for (int c = 0; c < 600 && k < 20; c++) begin
          @(negedge i_clk);
          i_ready = ~i_ready;
          if (o_valid && i_ready) begin
            check("wrap_data", o_data, 32'(8'h10 + k));
            k++;
          end
        end
        got_cnt = k;
      end
    join
    check("wrap_delivered", got_cnt, 20);
    check("wrap_acks",      ack_cnt, 20);
    i_ready = 1'b1;
    repeat (4) @(negedge i_clk);
    check("wrap_no_dup", o_valid, 0);

    // Mid-operation reset drops queued tokens
    i_ready = 1'b0;
    send(8'h31);
    send(8'h32);
    send(8'h33);
    check("midrst_valid_before", o_valid, 1);
    @(negedge i_clk);
    i_rstn  = 1'b0;
    i_req   = 1'b0;
    exp_ack = 1'b0;
    @(negedge i_clk);
    check("midrst_valid", o_valid, 0);
    check("midrst_ack",   o_ack,   0);
    check("midrst_data",  o_data,  0);
    i_rstn  = 1'b1;
    i_ready = 1'b1;
    seen    = 1'b0;
    repeat (8) begin
      @(negedge i_clk);
      if (o_valid !== 1'b0) seen = 1'b1;
    end
    check("midrst_no_data", seen,  0);
    check("midrst_ack_idle", o_ack, 0);

    // Double toggle without ack while the FIFO is full
    i_ready = 1'b0;
    for (int t = 0; t < 4; t++) send(8'(8'h50 + t));
    check("err_before", o_err, 0);
    @(negedge i_clk);
    i_data = 8'h54;
    i_req  = ~i_req;
    repeat (4) @(negedge i_clk);
    i_req  = ~i_req;
    repeat (4) @(negedge i_clk);
    check("err_set",    o_err, exp_err);
    repeat (5) @(negedge i_clk);
    check("err_sticky", o_err, exp_err);
    i_rstn = 1'b0;
    i_req  = 1'b0;
    @(negedge i_clk);
    check("err_rst",       o_err,   0);
    check("err_rst_valid", o_valid, 0);
    i_rstn = 1'b1;
    repeat (2) @(negedge i_clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
